timer_irq_dev: RTL and testbench
================================

# timer_irq_dev

Programmable 32-bit down-counting timer that sits on the CPU's peripheral bus, behind the system bridge. It drives one bit of the 6-bit hardware interrupt vector into CP0, so it is the interrupt source that CP0 samples. Software configures it through three word registers (CTRL, PRESET, COUNT). It either fires once and stops (mode 0) or reloads and fires periodically (mode 1).

## Interface
Parameters:
- none (register map and widths fixed).

Ports:
- clk  in  1  system clock; the block uses one clock.
- reset  in  1  synchronous, active-high reset.
- Addr  in  2  word select (bus address bits [3:2]): 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unused.
- We  in  1  write enable for the selected register; sampled on the clk rising edge.
- DIn  in  32  write data.
- DOut  out  32  read data; combinational from Addr.
- IRQ  out  1  interrupt request to CP0 HWInt bit; level signal.

## Operation
- CTRL[3:0] fields:
  - [0] Enable.
  - [2:1] Mode. 00 = one-shot; 01 = auto-reload; 10/11 behave as 00.
  - [3] IM, the interrupt mask (1 = IRQ allowed).
  - Bits [31:4] are not stored and read as 0.
- PRESET: 32-bit reload value, fully writable.
- COUNT: current count. Read-only; writes are ignored.
- DOut by Addr: 0 → {28'b0, CTRL[3:0]}; 1 → PRESET; 2 → COUNT; 3 → 0.
- Internal irq_pend flag; IRQ = irq_pend & CTRL[3].
- FSM states and transitions:
  - IDLE: if Enable = 1 → LOAD.
  - LOAD: COUNT ← PRESET; → CNT.
  - CNT:
    - If Enable = 0 → IDLE; COUNT holds its value.
    - Else if COUNT > 1 → COUNT − 1.
    - Else (COUNT is 0 or 1) → COUNT ← 0, irq_pend ← 1, → INT.
  - INT, mode 0: CTRL[0] ← 0, irq_pend stays 1, → IDLE.
  - INT, mode 1: irq_pend ← 0, → LOAD.
- Clearing irq_pend:
  - Any write to CTRL or to PRESET clears irq_pend.
  - Mode 0: IRQ stays high until software acknowledges it with one of those writes.
- Simultaneous events:
  - A CTRL write in the same cycle as INT's Enable clear: the bus write wins.
  - A PRESET write during CNT affects only the next LOAD.
  - A CTRL write clearing Enable while in INT: the next state is still IDLE (mode 0) or LOAD (mode 1). Mode 1 then goes LOAD → CNT → IDLE.
  - irq_pend clear (from a CTRL/PRESET write) and irq_pend set (CNT → INT) in the same cycle: the set wins.
- Preset of 0 behaves as preset of 1 (a single CNT cycle).

## Timing
- Reset values (at the clk edge with reset = 1):
  - CTRL = 0, PRESET = 0, COUNT = 0.
  - irq_pend = 0, state IDLE.
  - IRQ = 0, DOut = 0 for Addr 0/2/3.
- Reset mid-count aborts immediately; there are no residual pulses.
- Writes take effect at the clk edge where We = 1. Reads are same-cycle.
- Mode 0 latency: a write of Enable = 1 with PRESET = N (N ≥ 1) at edge E0 raises IRQ after edge E0 + N + 2:
  - E1: → LOAD.
  - E2: COUNT = N.
  - E2 + N: → INT with irq_pend set.
- Mode 1 period: N + 2 cycles (INT, LOAD, then N CNT cycles). IRQ is high for exactly 1 cycle per period, while the FSM is in INT.
- COUNT decrements once per cycle, with no wrap-around below 0.

## Configuration
- `TIMER_AUTORELOAD_EN` defined: mode 01 is auto-reload as described above.
- Not defined:
  - Mode bits are still stored and readable.
  - All modes behave as one-shot: INT → IDLE with Enable cleared, and irq_pend held until acknowledged.
  - Removes the INT → LOAD path.

## Test plan
- Reset, then read Addr 0/1/2/3 → all 0; IRQ = 0.
- PRESET = 5, CTRL = 0x9 (one-shot, IM = 1) at edge E0:
  - COUNT reads 5, 4, 3, 2, 1, 0.
  - IRQ rises after E0 + 7 and stays high.
  - CTRL reads 0x8.
  - A write of CTRL = 0x8 drops IRQ on the next cycle.
- PRESET = 3, CTRL = 0xB (auto-reload, macro defined): IRQ pulses 1 cycle wide every 5 cycles for 4 periods. Without the macro: a single IRQ that is held high.
- PRESET = 3, CTRL = 0x1 (IM = 0): the count completes and Enable clears, but IRQ stays 0. A later write of CTRL = 0x8 clears irq_pend and IRQ stays 0.
- Mid-count CTRL = 0x8 (Enable cleared) while COUNT = 10: COUNT freezes at 10, state is IDLE, no IRQ. Re-enabling reloads from PRESET.
- Writes to COUNT (0xFFFF) are ignored. Asserting reset during CNT with IRQ pending gives all-zero registers and IRQ = 0 on the next cycle.

Source files
------------

// File: rtl/timer_irq_dev.sv
// timer_irq_dev: 32-bit down-counting bus timer with one interrupt line to CP0.
// Registers (word select Addr): 0 = CTRL {IM, Mode[1:0], Enable}, 1 = PRESET,
// 2 = COUNT (read-only), 3 = unused.
// Optional feature macro: TIMER_AUTORELOAD_EN. When it is defined, Mode 01
// reloads PRESET after every expiry and fires periodically. When it is not
// defined, every mode behaves as one-shot.
module timer_irq_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    state_t      state;
    state_t      state_next;

    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_pend;

    logic [3:0]  ctrl_next;
    logic [31:0] preset_next;
    logic [31:0] count_next;
    logic        irq_pend_next;

    logic        ctrl_we;
    logic        preset_we;
    logic        enable;
    logic        count_done;
    logic        expire;
    logic        auto_reload;

    assign ctrl_we    = We && (Addr == ADDR_CTRL);
    assign preset_we  = We && (Addr == ADDR_PRESET);
    assign enable     = ctrl[0];

    // A count of 0 or 1 both end the run, so a preset of 0 acts like 1.
    assign count_done = (count <= 32'd1);
    assign expire     = (state == CNT) && enable && count_done;

`ifdef TIMER_AUTORELOAD_EN
    assign auto_reload = (ctrl[2:1] == 2'b01);
`else
    assign auto_reload = 1'b0;
`endif

    // State and register file update; a synchronous reset clears everything at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_pend <= 1'b0;
        end else begin
            state    <= state_next;
            ctrl     <= ctrl_next;
            preset   <= preset_next;
            count    <= count_next;
            irq_pend <= irq_pend_next;
        end
    end

    // Next-state logic: INT always leaves to LOAD or IDLE based on the stored mode,
    // even if software clears Enable in that same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = CNT;
            end
            CNT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (count_done) begin
                    state_next = INT;
                end
            end
            INT: begin
                state_next = auto_reload ? LOAD : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Register next values: FSM actions first, then bus writes override them, and
    // an expiry in the same cycle as an acknowledge still leaves the interrupt pending.
    always_comb begin
        ctrl_next     = ctrl;
        preset_next   = preset;
        count_next    = count;
        irq_pend_next = irq_pend;

        case (state)
            LOAD: begin
                count_next = preset;
            end
            CNT: begin
                if (enable) begin
                    count_next = count_done ? 32'd0 : (count - 32'd1);
                end
            end
            INT: begin
                if (auto_reload) begin
                    irq_pend_next = 1'b0;
                end else begin
                    ctrl_next[0] = 1'b0;
                end
            end
            default: begin
            end
        endcase

        if (ctrl_we) begin
            ctrl_next     = DIn[3:0];
            irq_pend_next = 1'b0;
        end

        if (preset_we) begin
            preset_next   = DIn;
            irq_pend_next = 1'b0;
        end

        if (expire) begin
            irq_pend_next = 1'b1;
        end
    end

    // Bus read mux and the masked interrupt level.
    always_comb begin
        DOut = 32'd0;
        case (Addr)
            ADDR_CTRL:   DOut = {28'd0, ctrl};
            ADDR_PRESET: DOut = preset;
            ADDR_COUNT:  DOut = count;
            default:     DOut = 32'd0;
        endcase
        IRQ = irq_pend & ctrl[3];
    end

endmodule

// File: tb/tb_timer_irq_dev.sv
// tb_timer_irq_dev: scenario tasks checked against a closed-form timing model
// of the timer (expected IRQ/COUNT/CTRL as functions of cycles since the enable write).
module tb_timer_irq_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    int errors;
    int checks;

`ifdef TIMER_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    timer_irq_dev dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .We    (We),
        .DIn   (DIn),
        .DOut  (DOut),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- reference model ----------------
    // Cycle k counts rising edges after the edge that wrote Enable = 1.
    // An effective length m = max(N,1) gives expiry after edge m+2, and a period of m+2.
    function automatic int eff_len(int n);
        return (n == 0) ? 1 : n;
    endfunction

    function automatic logic model_irq(int k, int n, bit im, bit periodic);
        int m;
        m = eff_len(n);
        if (!im || k < m + 2) return 1'b0;
        if (periodic) return ((k - (m + 2)) % (m + 2)) == 0;
        return 1'b1;
    endfunction

    // Valid for k >= 2: the count starts at N right after the load and falls by one per cycle.
    function automatic logic [31:0] model_count(int k, int n, bit periodic);
        int j;
        j = periodic ? ((k - 2) % (eff_len(n) + 2)) : (k - 2);
        return (j < n) ? 32'(n - j) : 32'd0;
    endfunction

    function automatic logic [31:0] model_ctrl(int k, int n, logic [3:0] cfg, bit periodic);
        if (!periodic && k >= eff_len(n) + 3) return {28'd0, cfg & 4'hE};
        return {28'd0, cfg};
    endfunction

    // ---------------- bus helpers ----------------
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = a;
        DIn  = d;
        We   = 1'b1;
        @(posedge clk);
        #1;
        We   = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
        Addr = a;
        #1;
        v = DOut;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        bus_write(2'd0, 32'd0);
        repeat (5) next_cycle();
        bus_write(2'd0, 32'd0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] v;
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_read addr=%0d: got %h, expected 0", a, v);
            end
        end
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_irq: got %b, expected 0", IRQ);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        int n;
        int m;
        for (int t = 0; t < 3; t++) begin
            n = (t == 0) ? 5 : ((t == 1) ? 0 : int'($urandom_range(1, 9)));
            m = eff_len(n);
            bus_write(2'd1, 32'(n));
            bus_write(2'd0, 32'h9);
            for (int k = 1; k <= m + 5; k++) begin
                next_cycle();
                if (k >= 2) begin
                    read_reg(2'd2, v);
                    checks++;
                    if (v !== model_count(k, n, 1'b0)) begin
                        errors++;
                        $display("[TB] FAIL oneshot_count n=%0d k=%0d: got %0d, expected %0d", n, k, v, model_count(k, n, 1'b0));
                    end
                end
                checks++;
                if (IRQ !== model_irq(k, n, 1'b1, 1'b0)) begin
                    errors++;
                    $display("[TB] FAIL oneshot_irq n=%0d k=%0d: got %b, expected %b", n, k, IRQ, model_irq(k, n, 1'b1, 1'b0));
                end
            end
            read_reg(2'd0, v);
            checks++;
            if (v !== 32'h8) begin
                errors++;
                $display("[TB] FAIL oneshot_ctrl n=%0d: got %h, expected 8", n, v);
            end
            bus_write(2'd0, 32'h8);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (IRQ !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL oneshot_ack n=%0d k=%0d: got %b, expected 0", n, k, IRQ);
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] v;
        int n;
        int m;
        for (int t = 0; t < 2; t++) begin
            n = (t == 0) ? 3 : int'($urandom_range(1, 6));
            m = eff_len(n);
            bus_write(2'd1, 32'(n));
            bus_write(2'd0, 32'hB);
            for (int k = 1; k <= 4 * (m + 2) + 1; k++) begin
                next_cycle();
                if (k >= 2) begin
                    read_reg(2'd2, v);
                    checks++;
                    if (v !== model_count(k, n, AUTO)) begin
                        errors++;
                        $display("[TB] FAIL auto_count n=%0d k=%0d: got %0d, expected %0d", n, k, v, model_count(k, n, AUTO));
                    end
                end
                checks++;
                if (IRQ !== model_irq(k, n, 1'b1, AUTO)) begin
                    errors++;
                    $display("[TB] FAIL auto_irq n=%0d k=%0d: got %b, expected %b", n, k, IRQ, model_irq(k, n, 1'b1, AUTO));
                end
            end
            quiesce();
        end
    endtask

    task automatic test_masked();
        logic [31:0] v;
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'h1);
        for (int k = 1; k <= 9; k++) begin
            next_cycle();
            checks++;
            if (IRQ !== 1'b0) begin
                errors++;
                $display("[TB] FAIL masked_irq k=%0d: got %b, expected 0", k, IRQ);
            end
        end
        read_reg(2'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("[TB] FAIL masked_ctrl: got %h, expected 0", v);
        end
        bus_write(2'd0, 32'h8);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (IRQ !== 1'b0) begin
                errors++;
                $display("[TB] FAIL masked_ack k=%0d: got %b, expected 0", k, IRQ);
            end
            next_cycle();
        end
        quiesce();
    endtask

    task automatic test_midcount_disable();
        logic [31:0] v;
        int n;
        n = int'($urandom_range(15, 30));
        bus_write(2'd1, 32'(n));
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= n - 9; k++) begin
            next_cycle();
            if (k >= 2) begin
                read_reg(2'd2, v);
                checks++;
                if (v !== model_count(k, n, 1'b0)) begin
                    errors++;
                    $display("[TB] FAIL mid_count n=%0d k=%0d: got %0d, expected %0d", n, k, v, model_count(k, n, 1'b0));
                end
            end
        end
        bus_write(2'd0, 32'h8);
        for (int k = 0; k < 5; k++) begin
            read_reg(2'd2, v);
            checks++;
            if (v !== 32'd10) begin
                errors++;
                $display("[TB] FAIL mid_freeze k=%0d: got %0d, expected 10", k, v);
            end
            checks++;
            if (IRQ !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mid_irq k=%0d: got %b, expected 0", k, IRQ);
            end
            next_cycle();
        end
        read_reg(2'd0, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("[TB] FAIL mid_ctrl: got %h, expected 8", v);
        end
        bus_write(2'd0, 32'h9);
        next_cycle();
        read_reg(2'd2, v);
        checks++;
        if (v !== 32'd10) begin
            errors++;
            $display("[TB] FAIL mid_reload_k1: got %0d, expected 10", v);
        end
        next_cycle();
        read_reg(2'd2, v);
        checks++;
        if (v !== 32'(n)) begin
            errors++;
            $display("[TB] FAIL mid_reload_k2: got %0d, expected %0d", v, n);
        end
        quiesce();
    endtask

    task automatic test_simultaneous();
        logic [31:0] v;
        // Acknowledge write landing on the expiry edge: the pending set wins.
        bus_write(2'd1, 32'd4);
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= 5; k++) next_cycle();
        bus_write(2'd1, 32'd6);
        checks++;
        if (IRQ !== 1'b1) begin
            errors++;
            $display("[TB] FAIL set_wins_irq: got %b, expected 1", IRQ);
        end
        read_reg(2'd1, v);
        checks++;
        if (v !== 32'd6) begin
            errors++;
            $display("[TB] FAIL set_wins_preset: got %0d, expected 6", v);
        end
        next_cycle();
        read_reg(2'd0, v);
        checks++;
        if (v !== 32'h8 || IRQ !== 1'b1) begin
            errors++;
            $display("[TB] FAIL set_wins_after: got ctrl=%h irq=%b, expected ctrl=8 irq=1", v, IRQ);
        end
        bus_write(2'd0, 32'h8);
        // CTRL write in the INT cycle: written Enable survives and the timer reruns.
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= 8; k++) next_cycle();
        checks++;
        if (IRQ !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_wins_pre: got %b, expected 1", IRQ);
        end
        bus_write(2'd0, 32'h9);
        read_reg(2'd0, v);
        checks++;
        if (v !== 32'h9 || IRQ !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_wins_ctrl: got ctrl=%h irq=%b, expected ctrl=9 irq=0", v, IRQ);
        end
        for (int k = 1; k <= 9; k++) begin
            next_cycle();
            checks++;
            if (IRQ !== model_irq(k, 6, 1'b1, 1'b0)) begin
                errors++;
                $display("[TB] FAIL write_wins_rerun k=%0d: got %b, expected %b", k, IRQ, model_irq(k, 6, 1'b1, 1'b0));
            end
        end
        quiesce();
    endtask

    task automatic test_count_write();
        logic [31:0] v;
        bus_write(2'd1, 32'd20);
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= 10; k++) begin
            if (k == 7) bus_write(2'd2, 32'hFFFF);
            else next_cycle();
            if (k >= 2) begin
                read_reg(2'd2, v);
                checks++;
                if (v !== model_count(k, 20, 1'b0)) begin
                    errors++;
                    $display("[TB] FAIL count_write k=%0d: got %0d, expected %0d", k, v, model_count(k, 20, 1'b0));
                end
            end
        end
        read_reg(2'd3, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("[TB] FAIL unused_addr: got %h, expected 0", v);
        end
        quiesce();
    endtask

    task automatic test_reset_midcount();
        logic [31:0] v;
        for (int t = 0; t < 2; t++) begin
            bus_write(2'd1, (t == 0) ? 32'd7 : 32'd2);
            bus_write(2'd0, 32'h9);
            for (int k = 1; k <= 5; k++) next_cycle();
            if (t == 1) begin
                checks++;
                if (IRQ !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rst_pre_irq: got %b, expected 1", IRQ);
                end
            end
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            for (int a = 0; a < 3; a++) begin
                read_reg(2'(a), v);
                checks++;
                if (v !== 32'd0) begin
                    errors++;
                    $display("[TB] FAIL rst_mid_read t=%0d addr=%0d: got %h, expected 0", t, a, v);
                end
            end
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (IRQ !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rst_mid_irq t=%0d k=%0d: got %b, expected 0", t, k, IRQ);
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [3:0]  cfg;
        int n;
        int m;
        int last;
        bit periodic;
        for (int t = 0; t < 8; t++) begin
            n        = int'($urandom_range(0, 9));
            m        = eff_len(n);
            cfg      = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
            periodic = AUTO && (cfg[2:1] == 2'b01);
            last     = periodic ? (3 * (m + 2) + 1) : (m + 5);
            bus_write(2'd1, 32'(n));
            bus_write(2'd0, {28'd0, cfg});
            for (int k = 1; k <= last; k++) begin
                next_cycle();
                checks++;
                if (IRQ !== model_irq(k, n, cfg[3], periodic)) begin
                    errors++;
                    $display("[TB] FAIL rand_irq cfg=%h n=%0d k=%0d: got %b, expected %b", cfg, n, k, IRQ, model_irq(k, n, cfg[3], periodic));
                end
                read_reg(2'd0, v);
                checks++;
                if (v !== model_ctrl(k, n, cfg, periodic)) begin
                    errors++;
                    $display("[TB] FAIL rand_ctrl cfg=%h n=%0d k=%0d: got %h, expected %h", cfg, n, k, v, model_ctrl(k, n, cfg, periodic));
                end
                if (k >= 2) begin
                    read_reg(2'd2, v);
                    checks++;
                    if (v !== model_count(k, n, periodic)) begin
                        errors++;
                        $display("[TB] FAIL rand_count cfg=%h n=%0d k=%0d: got %0d, expected %0d", cfg, n, k, v, model_count(k, n, periodic));
                    end
                end
            end
            quiesce();
        end
    endtask

    // Watchdog: every scenario uses fixed cycle counts, so this only trips on a broken run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        Addr   = 2'd0;
        We     = 1'b0;
        DIn    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        test_reset();
        test_oneshot();
        test_autoreload();
        test_masked();
        test_midcount_disable();
        test_simultaneous();
        test_count_write();
        test_reset_midcount();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
